if_stage: RTL and testbench

- Instruction-fetch stage with built-in IF/ID pipeline register. Directly upstream of the ID decoder; supplies `inst`/`pc` to it.
- Owns the fetch PC and drives a req/ack instruction-memory port that tolerates wait states.
- Obeys the ID stall request and takes branch/jump redirects from ID with MIPS single-delay-slot semantics.
- Inserts nop bubbles (`inst`=0) whenever no instruction is available.

---
 rtl/if_stage.sv | 116 +++++++++++
 tb/tb_if_stage.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage with an IF/ID output register, a one-entry stall buffer
// and MIPS single-delay-slot redirect handling on a req/ack memory port.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branchEN,
  input  logic [31:0] branchAddr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t      state, state_nx;
  logic [31:0] fetch_pc, fetch_pc_nx;
  logic        redir_pending, redir_pending_nx;
  logic [31:0] redir_addr, redir_addr_nx;
  logic [31:0] buf_inst, buf_inst_nx;
  logic [31:0] buf_pc, buf_pc_nx;
  logic [31:0] pc_nx, inst_nx;
  logic        inst_valid_nx;
  logic        take_br;

  assign imem_req  = (state == FETCH);
  assign imem_addr = fetch_pc;
  assign take_br   = branchEN && !stall;

  always_comb begin
    state_nx         = state;
    fetch_pc_nx      = fetch_pc;
    redir_pending_nx = redir_pending;
    redir_addr_nx    = redir_addr;
    buf_inst_nx      = buf_inst;
    buf_pc_nx        = buf_pc;
    pc_nx            = pc;
    inst_nx          = inst;
    inst_valid_nx    = inst_valid;
    case (state)
      IDLE: state_nx = FETCH;
      FETCH: begin
        if (imem_ack) begin
          // The acked word is the delay slot, so any redirect steers the following fetch.
          if (take_br)
            fetch_pc_nx = branchAddr;
          else if (redir_pending)
            fetch_pc_nx = redir_addr;
          else
            fetch_pc_nx = fetch_pc + 32'd4;
          redir_pending_nx = 1'b0;
          if (stall) begin
            buf_inst_nx = imem_rdata;
            buf_pc_nx   = fetch_pc;
            state_nx    = HOLD;
          end else begin
            inst_nx       = imem_rdata;
            pc_nx         = fetch_pc;
            inst_valid_nx = 1'b1;
          end
        end else begin
          if (take_br) begin
            redir_pending_nx = 1'b1;
            redir_addr_nx    = branchAddr;
          end
          if (!stall) begin
            inst_nx       = 32'h0;
            inst_valid_nx = 1'b0;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          inst_nx       = buf_inst;
          pc_nx         = buf_pc;
          inst_valid_nx = 1'b1;
          state_nx      = FETCH;
          if (branchEN)
            fetch_pc_nx = branchAddr;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      fetch_pc      <= RESET_PC;
      redir_pending <= 1'b0;
      redir_addr    <= 32'h0;
      buf_inst      <= 32'h0;
      buf_pc        <= 32'h0;
      pc            <= 32'h0;
      inst          <= 32'h0;
      inst_valid    <= 1'b0;
    end else begin
      state         <= state_nx;
      fetch_pc      <= fetch_pc_nx;
      redir_pending <= redir_pending_nx;
      redir_addr    <= redir_addr_nx;
      buf_inst      <= buf_inst_nx;
      buf_pc        <= buf_pc_nx;
      pc            <= pc_nx;
      inst          <= inst_nx;
      inst_valid    <= inst_valid_nx;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, a hand-written redirect-overwrite
// sequence, then random traffic checked against a queue-based delivery model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst, stall, branchEN, imem_ack;
  logic [31:0] branchAddr, imem_rdata;
  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, pc, inst;

  int total  = 0;
  int passed = 0;

  if_stage #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branchEN(branchEN), .branchAddr(branchAddr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc(pc), .inst(inst), .inst_valid(inst_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall, ack, br;
    logic [31:0] baddr;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc, inst;
  } vec_t;

  typedef struct {
    logic [31:0] pc, inst;
  } word_t;

  vec_t  vecs[$];
  word_t pend_q[$];
  word_t w;
  logic        m_idle, m_tgt_v, m_valid;
  logic [31:0] m_addr, m_tgt, m_pc, m_inst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Drives one cycle of inputs (caller is at a negedge) and returns #1 after the edge.
  task automatic apply_stimulus(input logic r, input logic s, input logic a, input logic b,
                                input logic [31:0] ba, input logic [31:0] d);
    rst = r; stall = s; imem_ack = a; branchEN = b; branchAddr = ba; imem_rdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic req, input logic [31:0] addr,
                              input logic valid, input logic [31:0] p, input logic [31:0] ins);
    check({tag, " req"},   {31'h0, imem_req},   {31'h0, req});
    check({tag, " addr"},  imem_addr,           addr);
    check({tag, " valid"}, {31'h0, inst_valid}, {31'h0, valid});
    check({tag, " pc"},    pc,                  p);
    check({tag, " inst"},  inst,                ins);
  endtask

  // Delivery model: acked words queue up and ID takes the oldest one in every non-stalled cycle.
  task automatic model_step(input logic r, input logic s, input logic a, input logic b,
                            input logic [31:0] ba, input logic [31:0] d);
    logic had_buf;
    if (!r) begin
      pend_q.delete();
      m_idle = 1'b1; m_tgt_v = 1'b0; m_addr = 32'h0;
      m_valid = 1'b0; m_pc = 32'h0; m_inst = 32'h0;
    end else if (m_idle) begin
      m_idle = 1'b0;
    end else begin
      had_buf = (pend_q.size() != 0);
      if (a) begin
        pend_q.push_back('{m_addr, d});
        if (b && !s) m_addr = ba;
        else if (m_tgt_v) m_addr = m_tgt;
        else m_addr = m_addr + 32'd4;
        m_tgt_v = 1'b0;
      end else if (b && !s) begin
        if (had_buf) m_addr = ba;
        else begin
          m_tgt_v = 1'b1;
          m_tgt   = ba;
        end
      end
      if (!s) begin
        if (pend_q.size() != 0) begin
          w = pend_q.pop_front();
          m_valid = 1'b1; m_pc = w.pc; m_inst = w.inst;
        end else begin
          m_valid = 1'b0; m_inst = 32'h0;
        end
      end
    end
  endtask

  initial begin
    logic        r, s, a, b;
    logic [31:0] ba, d;
    rst = 1'b0; stall = 1'b0; imem_ack = 1'b0; branchEN = 1'b0;
    branchAddr = 32'h0; imem_rdata = 32'h0;

    vecs.push_back('{0,0,0,0,32'h0,   0,32'h0,   0,32'h0,32'h0});
    vecs.push_back('{0,0,0,0,32'h0,   0,32'h0,   0,32'h0,32'h0});
    vecs.push_back('{1,0,0,0,32'h0,   1,32'h0,   0,32'h0,32'h0});
    vecs.push_back('{1,0,1,0,32'h0,   1,32'h4,   1,32'h0,32'h1000_0000});
    vecs.push_back('{1,0,0,0,32'h0,   1,32'h4,   0,32'h0,32'h0});
    vecs.push_back('{1,0,0,0,32'h0,   1,32'h4,   0,32'h0,32'h0});
    vecs.push_back('{1,0,1,0,32'h0,   1,32'h8,   1,32'h4,32'h1000_0004});
    vecs.push_back('{1,1,1,0,32'h0,   0,32'hC,   1,32'h4,32'h1000_0004});
    vecs.push_back('{1,1,0,0,32'h0,   0,32'hC,   1,32'h4,32'h1000_0004});
    vecs.push_back('{1,1,0,0,32'h0,   0,32'hC,   1,32'h4,32'h1000_0004});
    vecs.push_back('{1,1,0,0,32'h0,   0,32'hC,   1,32'h4,32'h1000_0004});
    vecs.push_back('{1,0,0,0,32'h0,   1,32'hC,   1,32'h8,32'h1000_0008});
    vecs.push_back('{1,0,1,0,32'h0,   1,32'h10,  1,32'hC,32'h1000_000C});
    vecs.push_back('{1,0,1,0,32'h0,   1,32'h14,  1,32'h10,32'h1000_0010});
    vecs.push_back('{1,0,0,1,32'h100, 1,32'h14,  0,32'h10,32'h0});
    vecs.push_back('{1,0,0,0,32'h0,   1,32'h14,  0,32'h10,32'h0});
    vecs.push_back('{1,0,1,0,32'h0,   1,32'h100, 1,32'h14,32'h1000_0014});
    vecs.push_back('{1,0,1,0,32'h0,   1,32'h104, 1,32'h100,32'h1000_0100});
    vecs.push_back('{1,0,1,0,32'h0,   1,32'h108, 1,32'h104,32'h1000_0104});
    vecs.push_back('{1,1,1,0,32'h0,   0,32'h10C, 1,32'h104,32'h1000_0104});
    vecs.push_back('{1,1,0,1,32'h200, 0,32'h10C, 1,32'h104,32'h1000_0104});
    vecs.push_back('{1,1,0,1,32'h200, 0,32'h10C, 1,32'h104,32'h1000_0104});
    vecs.push_back('{1,0,0,1,32'h200, 1,32'h200, 1,32'h108,32'h1000_0108});
    vecs.push_back('{1,0,1,0,32'h0,   1,32'h204, 1,32'h200,32'h1000_0200});
    vecs.push_back('{1,0,0,0,32'h0,   1,32'h204, 0,32'h200,32'h0});
    vecs.push_back('{0,0,0,0,32'h0,   0,32'h0,   0,32'h0,32'h0});
    vecs.push_back('{1,0,1,0,32'h0,   1,32'h0,   0,32'h0,32'h0});
    vecs.push_back('{1,0,0,0,32'h0,   1,32'h0,   0,32'h0,32'h0});
    vecs.push_back('{1,0,1,0,32'h0,   1,32'h4,   1,32'h0,32'h1000_0000});
    vecs.push_back('{1,0,1,1,32'hFFFF_FFFC, 1,32'hFFFF_FFFC, 1,32'h4,32'h1000_0004});
    vecs.push_back('{1,0,1,0,32'h0,   1,32'h0,   1,32'hFFFF_FFFC,32'h0FFF_FFFC});
    vecs.push_back('{1,0,1,1,32'h303, 1,32'h303, 1,32'h0,32'h1000_0000});
    vecs.push_back('{1,0,1,0,32'h0,   1,32'h307, 1,32'h303,32'h1000_0303});

    foreach (vecs[i]) begin
      @(negedge clk);
      apply_stimulus(vecs[i].rst, vecs[i].stall, vecs[i].ack, vecs[i].br, vecs[i].baddr,
                     imem_addr + 32'h1000_0000);
      check_output($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].valid,
                   vecs[i].pc, vecs[i].inst);
    end

    // Second redirect while the first is still pending: the later target wins.
    @(negedge clk);
    apply_stimulus(1, 0, 0, 1, 32'h400, 32'h0);
    check_output("ovr1", 1, 32'h307, 0, 32'h303, 32'h0);
    @(negedge clk);
    $display("[TB] warning: second redirect issued while one is pending");
    apply_stimulus(1, 0, 0, 1, 32'h500, 32'h0);
    check_output("ovr2", 1, 32'h307, 0, 32'h303, 32'h0);
    @(negedge clk);
    apply_stimulus(1, 0, 1, 0, 32'h0, imem_addr + 32'h1000_0000);
    check_output("ovr3", 1, 32'h500, 1, 32'h307, 32'h1000_0307);

    pend_q.delete();
    m_idle = 1'b1; m_tgt_v = 1'b0; m_addr = 32'h0; m_tgt = 32'h0;
    m_valid = 1'b0; m_pc = 32'h0; m_inst = 32'h0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      r  = (c < 2) ? 1'b0 : ($urandom_range(0, 149) != 0);
      s  = ($urandom_range(0, 3) == 0);
      a  = imem_req && ($urandom_range(0, 2) != 0);
      b  = !m_idle && ($urandom_range(0, 7) == 0);
      ba = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      d  = $urandom;
      model_step(r, s, a, b, ba, d);
      apply_stimulus(r, s, a, b, ba, d);
      check_output($sformatf("rnd%0d", c), !m_idle && (pend_q.size() == 0), m_addr,
                   m_valid, m_pc, m_inst);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
